// File: rtl/apb_mbox_pkg.sv
// apb_mbox_pkg
// Shared definitions for the APB mailbox slave: register byte offsets, bit
// positions inside STATUS/CTRL/ISR, field widths and the APB FSM state enum.
// No ports (package).
package apb_mbox_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 9;
    localparam int unsigned WAIT_W  = 4;

    // Register byte offsets; PADDR[1:0] is ignored when decoding
    localparam int unsigned OFF_DATA   = 32'h00;
    localparam int unsigned OFF_STATUS = 32'h04;
    localparam int unsigned OFF_CTRL   = 32'h08;
    localparam int unsigned OFF_ISR    = 32'h0C;

    // STATUS fields
    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_COUNT_LSB = 8;

    // CTRL fields
    localparam int unsigned CTRL_IE_BIT    = 0;
    localparam int unsigned CTRL_FLUSH_BIT = 1;
    localparam int unsigned CTRL_WAIT_LSB  = 4;

    // ISR fields
    localparam int unsigned ISR_OVF_BIT = 0;
    localparam int unsigned ISR_UNF_BIT = 1;
    localparam int unsigned ISR_NE_BIT  = 2;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_mbox_if.sv
// apb_mbox_if
// APB3 bus bundle between the bridge (master) and the mailbox (slave).
// Signals:
//   PSEL, PENABLE, PWRITE, PADDR[ADDR_WIDTH], PWDATA[32]  master -> slave
//   PRDATA[32], PREADY, PSLVERR                           slave -> master
// Modports: master, slave.
interface apb_mbox_if
    import apb_mbox_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
);

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_mbox_fifo.sv
// apb_mbox_fifo
// DEPTH-entry, 32-bit synchronous FIFO backing the mailbox DATA register.
// Ports:
//   PCLK, PRESET      clock, synchronous active-high reset
//   push, wdata       enqueue wdata (ignored when full)
//   pop               dequeue head (ignored when empty)
//   flush             drop all entries (pointers and count cleared)
//   rdata             current head entry
//   empty, full       occupancy flags
//   count[9]          number of stored entries
module apb_mbox_fifo
    import apb_mbox_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               empty,
    output logic               full,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    logic do_push;
    logic do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign rdata = mem[rptr];

    // Guard here as well so a misbehaving parent cannot corrupt the pointers
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage carries no reset; only the pointers define which words are valid
    always_ff @(posedge PCLK) begin
        if (!PRESET && !flush && do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are PTR_W bits wide, so incrementing wraps modulo DEPTH
    always_ff @(posedge PCLK) begin
        if (PRESET || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_mbox_slave.sv
// apb_mbox_slave
// APB3 mailbox slave: a 32-bit FIFO behind a DATA register, with STATUS,
// CTRL (IE, FLUSH, WAIT) and ISR (OVF, UNF, NE) registers, programmable wait
// states and a level interrupt.
// Ports:
//   PCLK, PRESET   clock, synchronous active-high reset
//   bus            apb_mbox_if.slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//                  PRDATA/PREADY/PSLVERR out)
//   INT            level interrupt, IE & (OVF | UNF | NE)
// Build option:
//   APB_MBOX_PSLVERR_EN  when defined, PSLVERR flags overflow pushes,
//                        underflow pops and unmapped accesses; otherwise
//                        PSLVERR is tied low.
module apb_mbox_slave
    import apb_mbox_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int RESET_WAIT = 0
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_mbox_if.slave      bus,
    output logic           INT
);

    apb_state_e          state;
    logic [WAIT_W-1:0]   wcnt;

    logic                ctrl_ie;
    logic [WAIT_W-1:0]   ctrl_wait;
    logic                isr_ovf;
    logic                isr_unf;

    logic [DATA_W-1:0]   fifo_rdata;
    logic                fifo_empty;
    logic                fifo_full;
    logic [COUNT_W-1:0]  fifo_count;

    logic [ADDR_WIDTH-1:0] addr_word;
    logic                hit_data;
    logic                hit_status;
    logic                hit_ctrl;
    logic                hit_isr;
    logic                mapped;

    logic                pready;
    logic                wr_done;
    logic                rd_done;
    logic                push;
    logic                pop;
    logic                flush;
    logic                ovf_evt;
    logic                unf_evt;
    logic                err_cond;
    logic                isr_w1c;
    logic [DATA_W-1:0]   rd_val;
    logic [1:0]          unused_addr_lsbs;

    // Address decode works on word addresses; the byte lane bits are ignored
    assign addr_word        = {bus.PADDR[ADDR_WIDTH-1:2], 2'b00};
    assign unused_addr_lsbs = bus.PADDR[1:0];
    assign hit_data         = (addr_word == ADDR_WIDTH'(OFF_DATA));
    assign hit_status       = (addr_word == ADDR_WIDTH'(OFF_STATUS));
    assign hit_ctrl         = (addr_word == ADDR_WIDTH'(OFF_CTRL));
    assign hit_isr          = (addr_word == ADDR_WIDTH'(OFF_ISR));
    assign mapped           = hit_data | hit_status | hit_ctrl | hit_isr;

    // PREADY is combinational so a zero-wait transfer completes in its first
    // access cycle; reset masks it so nothing can commit while PRESET is high
    assign pready  = ~PRESET & (state == ST_ACCESS) & bus.PSEL & bus.PENABLE
                   & (wcnt == '0);
    assign wr_done = pready & bus.PWRITE;
    assign rd_done = pready & ~bus.PWRITE;

    assign push    = wr_done & hit_data & ~fifo_full;
    assign ovf_evt = wr_done & hit_data & fifo_full;
    assign pop     = rd_done & hit_data & ~fifo_empty;
    assign unf_evt = rd_done & hit_data & fifo_empty;
    assign flush   = wr_done & hit_ctrl & bus.PWDATA[CTRL_FLUSH_BIT];
    assign isr_w1c = wr_done & hit_isr;

    assign err_cond = ovf_evt | unf_evt | (pready & ~mapped);

    apb_mbox_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .wdata  (bus.PWDATA),
        .rdata  (fifo_rdata),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    // APB handshake FSM. The wait count is loaded at setup from the CTRL.WAIT
    // value current at that moment, so a CTRL write only affects later
    // transfers. Dropping PSEL in ACCESS abandons the transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.PSEL && !bus.PENABLE) begin
                        state <= ST_ACCESS;
                        wcnt  <= ctrl_wait;
                    end
                end
                ST_ACCESS: begin
                    if (!bus.PSEL) begin
                        state <= ST_IDLE;
                    end else if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else if (bus.PENABLE) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // CTRL register; FLUSH is a pulse and is not stored
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_ie   <= 1'b0;
            ctrl_wait <= WAIT_W'(RESET_WAIT);
        end else if (wr_done && hit_ctrl) begin
            ctrl_ie   <= bus.PWDATA[CTRL_IE_BIT];
            ctrl_wait <= bus.PWDATA[CTRL_WAIT_LSB +: WAIT_W];
        end
    end

    // Sticky error flags; a new event beats a simultaneous W1C clear
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            isr_ovf <= 1'b0;
            isr_unf <= 1'b0;
        end else begin
            isr_ovf <= (isr_ovf & ~(isr_w1c & bus.PWDATA[ISR_OVF_BIT])) | ovf_evt;
            isr_unf <= (isr_unf & ~(isr_w1c & bus.PWDATA[ISR_UNF_BIT])) | unf_evt;
        end
    end

    // Read data mux; an empty DATA read and unmapped reads return zero
    always_comb begin
        rd_val = '0;
        if (hit_data) begin
            rd_val = fifo_empty ? '0 : fifo_rdata;
        end else if (hit_status) begin
            rd_val[STATUS_EMPTY_BIT]             = fifo_empty;
            rd_val[STATUS_FULL_BIT]              = fifo_full;
            rd_val[STATUS_COUNT_LSB +: COUNT_W]  = fifo_count;
        end else if (hit_ctrl) begin
            rd_val[CTRL_IE_BIT]                  = ctrl_ie;
            rd_val[CTRL_WAIT_LSB +: WAIT_W]      = ctrl_wait;
        end else if (hit_isr) begin
            rd_val[ISR_OVF_BIT]                  = isr_ovf;
            rd_val[ISR_UNF_BIT]                  = isr_unf;
            rd_val[ISR_NE_BIT]                   = ~fifo_empty;
        end
    end

    assign bus.PREADY = pready;
    assign bus.PRDATA = rd_done ? rd_val : '0;

`ifdef APB_MBOX_PSLVERR_EN
    assign bus.PSLVERR = err_cond;
`else
    logic unused_err_cond;
    assign unused_err_cond = err_cond;
    assign bus.PSLVERR     = 1'b0;
`endif

    assign INT = ~PRESET & ctrl_ie & (isr_ovf | isr_unf | ~fifo_empty);

endmodule

// File: tb/tb_apb_mbox_slave.sv
// tb_apb_mbox_slave
// Self-checking bench for apb_mbox_slave: a table of directed transfers with
// hand-computed results, hand-written sequences for fill/overflow/wrap,
// flush, wait states and reset during a wait state, then randomized traffic
// checked against a queue-based mailbox model.
module tb_apb_mbox_slave;

    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int RESET_WAIT = 0;

`ifdef APB_MBOX_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic PCLK;
    logic PRESET;
    logic int_line;

    apb_mbox_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    apb_mbox_slave #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_WAIT (RESET_WAIT)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus),
        .INT    (int_line)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_vectors;
    int n_miscompares;

    // Results of the most recent transfer
    logic [31:0] last_rd;
    logic        last_err;
    int          last_waits;
    logic        last_int;

    // Mailbox reference model
    logic [31:0] mq[$];
    bit          m_ie;
    int          m_wait;
    bit          m_ovf;
    bit          m_unf;

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
        logic        exp_int;
    } vec_t;

    vec_t vecs[22];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_ie   = 1'b0;
        m_wait = RESET_WAIT;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    function automatic logic modelInt();
        return m_ie & (m_ovf | m_unf | (mq.size() != 0));
    endfunction

    // Computes the expected bus response and advances the model state
    task automatic modelStep(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                             output logic [31:0] exp_rd, output logic exp_err, output int exp_waits);
        int off;
        exp_rd    = 32'h0;
        exp_err   = 1'b0;
        exp_waits = m_wait;
        off       = int'(addr) & 32'hFC;
        case (off)
            'h00: begin
                if (wr) begin
                    if (mq.size() == DEPTH) begin
                        m_ovf   = 1'b1;
                        exp_err = 1'b1;
                    end else begin
                        mq.push_back(wd);
                    end
                end else begin
                    if (mq.size() == 0) begin
                        m_unf   = 1'b1;
                        exp_err = 1'b1;
                    end else begin
                        exp_rd = mq.pop_front();
                    end
                end
            end
            'h04: begin
                if (!wr) begin
                    exp_rd = (32'(mq.size()) << 8) | (32'(mq.size() == DEPTH) << 1)
                           | 32'(mq.size() == 0);
                end
            end
            'h08: begin
                if (wr) begin
                    m_ie   = wd[0];
                    m_wait = int'(wd[7:4]);
                    if (wd[1]) mq.delete();
                end else begin
                    exp_rd = (32'(m_wait) << 4) | 32'(m_ie);
                end
            end
            'h0C: begin
                if (wr) begin
                    if (wd[0]) m_ovf = 1'b0;
                    if (wd[1]) m_unf = 1'b0;
                end else begin
                    exp_rd = 32'(m_ovf) | (32'(m_unf) << 1) | (32'(mq.size() != 0) << 2);
                end
            end
            default: exp_err = 1'b1;
        endcase
    endtask

    // One APB transfer: setup, access until PREADY (bounded), then idle
    task automatic apbXfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err, output int waits);
        bit done;
        @(negedge PCLK);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wd;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        waits = 0;
        done  = 1'b0;
        rd    = 32'h0;
        err   = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (bus.PREADY === 1'b1) begin
                rd   = bus.PRDATA;
                err  = bus.PSLVERR;
                done = 1'b1;
            end else begin
                waits++;
                @(negedge PCLK);
            end
        end
        if (!done) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL pready_timeout: got no PREADY after %0d cycles, expected PREADY", waits);
            waits = -1;
        end
        @(negedge PCLK);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                                 input string tag);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_waits;
        modelStep(wr, addr, wd, exp_rd, exp_err, exp_waits);
        apbXfer(wr, addr, wd, last_rd, last_err, last_waits);
        last_int = int_line;
        checkOutput({tag, " prdata"},  last_rd, exp_rd);
        checkOutput({tag, " pslverr"}, 32'(last_err), 32'(ERR_EN & exp_err));
        checkOutput({tag, " waits"},   32'(last_waits), 32'(exp_waits));
        checkOutput({tag, " int"},     32'(last_int), 32'(modelInt()));
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        bus.PWRITE    = 1'b0;
        bus.PADDR     = '0;
        bus.PWDATA    = '0;
        modelReset();

        //            wr    addr   wdata         rdata         err  waits int
        vecs[0]  = '{1'b1, 8'h00, 32'hA5A50001, 32'h0,        1'b0, 0, 1'b0};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,        32'h00000100, 1'b0, 0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 32'h0,        32'hA5A50001, 1'b0, 0, 1'b0};
        vecs[3]  = '{1'b0, 8'h04, 32'h0,        32'h00000001, 1'b0, 0, 1'b0};
        vecs[4]  = '{1'b0, 8'h0C, 32'h0,        32'h0,        1'b0, 0, 1'b0};
        vecs[5]  = '{1'b0, 8'h08, 32'h0,        32'h0,        1'b0, 0, 1'b0};
        vecs[6]  = '{1'b1, 8'h08, 32'h00000031, 32'h0,        1'b0, 0, 1'b0};
        vecs[7]  = '{1'b0, 8'h08, 32'h0,        32'h00000031, 1'b0, 3, 1'b0};
        vecs[8]  = '{1'b0, 8'h07, 32'h0,        32'h00000001, 1'b0, 3, 1'b0};
        vecs[9]  = '{1'b1, 8'h08, 32'h00000001, 32'h0,        1'b0, 3, 1'b0};
        vecs[10] = '{1'b0, 8'h10, 32'h0,        32'h0,        1'b1, 0, 1'b0};
        vecs[11] = '{1'b1, 8'h84, 32'h00000123, 32'h0,        1'b1, 0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 32'h0,        32'h0,        1'b1, 0, 1'b1};
        vecs[13] = '{1'b0, 8'h0C, 32'h0,        32'h00000002, 1'b0, 0, 1'b1};
        vecs[14] = '{1'b1, 8'h0C, 32'h00000003, 32'h0,        1'b0, 0, 1'b0};
        vecs[15] = '{1'b0, 8'h0C, 32'h0,        32'h0,        1'b0, 0, 1'b0};
        vecs[16] = '{1'b1, 8'h04, 32'h0000FFFF, 32'h0,        1'b0, 0, 1'b0};
        vecs[17] = '{1'b0, 8'h04, 32'h0,        32'h00000001, 1'b0, 0, 1'b0};
        vecs[18] = '{1'b1, 8'h00, 32'h00000055, 32'h0,        1'b0, 0, 1'b1};
        vecs[19] = '{1'b0, 8'h0C, 32'h0,        32'h00000004, 1'b0, 0, 1'b1};
        vecs[20] = '{1'b0, 8'h00, 32'h0,        32'h00000055, 1'b0, 0, 1'b0};
        vecs[21] = '{1'b1, 8'h08, 32'h0,        32'h0,        1'b0, 0, 1'b0};

        // Reset and idle outputs
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        #1;
        checkOutput("reset pready",  32'(bus.PREADY),  32'h0);
        checkOutput("reset pslverr", 32'(bus.PSLVERR), 32'h0);
        checkOutput("reset prdata",  bus.PRDATA,       32'h0);
        checkOutput("reset int",     32'(int_line),    32'h0);
        PRESET = 1'b0;
        @(negedge PCLK);
        #1;
        checkOutput("post-reset pready", 32'(bus.PREADY), 32'h0);

        // Directed table
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
            checkOutput($sformatf("tbl%0d prdata", i),  last_rd, vecs[i].exp_rdata);
            checkOutput($sformatf("tbl%0d pslverr", i), 32'(last_err), 32'(ERR_EN & vecs[i].exp_err));
            checkOutput($sformatf("tbl%0d waits", i),   32'(last_waits), 32'(vecs[i].exp_waits));
            checkOutput($sformatf("tbl%0d int", i),     32'(last_int), 32'(vecs[i].exp_int));
        end

        // Fill to DEPTH, overflow, drain in order, then one wrap pair
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'h00, 32'(i), "fill");
        applyStimulus(1'b0, 8'h04, 32'h0, "full status");
        checkOutput("full status const", last_rd, 32'h00001002);
        applyStimulus(1'b1, 8'h00, 32'h0000DEAD, "overflow");
        checkOutput("overflow pslverr const", 32'(last_err), 32'(ERR_EN));
        applyStimulus(1'b0, 8'h0C, 32'h0, "ovf isr");
        checkOutput("ovf isr const", last_rd, 32'h00000005);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 32'h0, "drain");
            checkOutput($sformatf("drain%0d const", i), last_rd, 32'(i));
        end
        applyStimulus(1'b1, 8'h00, 32'hCAFE0001, "wrap push");
        applyStimulus(1'b0, 8'h00, 32'h0, "wrap pop");
        checkOutput("wrap pop const", last_rd, 32'hCAFE0001);
        applyStimulus(1'b1, 8'h0C, 32'h00000001, "clear ovf");

        // Flush with entries present
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h00, 32'h100 + 32'(i), "pre-flush");
        applyStimulus(1'b1, 8'h08, 32'h00000002, "flush");
        applyStimulus(1'b0, 8'h04, 32'h0, "flush status");
        checkOutput("flush status const", last_rd, 32'h00000001);
        applyStimulus(1'b0, 8'h0C, 32'h0, "flush isr");
        checkOutput("flush isr const", last_rd, 32'h0);

        // Three wait states, one commit
        applyStimulus(1'b1, 8'h08, 32'h00000030, "wait3 ctrl");
        applyStimulus(1'b1, 8'h00, 32'h00000077, "wait3 push");
        checkOutput("wait3 push waits const", 32'(last_waits), 32'd3);
        applyStimulus(1'b0, 8'h04, 32'h0, "wait3 status");
        checkOutput("wait3 status const", last_rd, 32'h00000100);

        // Reset asserted in the completion cycle of a WAIT=5 DATA write
        applyStimulus(1'b1, 8'h08, 32'h00000050, "wait5 ctrl");
        @(negedge PCLK);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 8'h00;
        bus.PWDATA  = 32'hBAD0BAD0;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge PCLK);
            #1;
            checkOutput($sformatf("wait5 cycle%0d pready", c + 1), 32'(bus.PREADY), 32'h0);
        end
        @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        checkOutput("midreset pready",  32'(bus.PREADY),  32'h0);
        checkOutput("midreset pslverr", 32'(bus.PSLVERR), 32'h0);
        checkOutput("midreset prdata",  bus.PRDATA,       32'h0);
        checkOutput("midreset int",     32'(int_line),    32'h0);
        @(negedge PCLK);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        checkOutput("after midreset pready", 32'(bus.PREADY), 32'h0);
        modelReset();
        applyStimulus(1'b0, 8'h04, 32'h0, "after midreset status");
        checkOutput("after midreset status const", last_rd, 32'h00000001);
        applyStimulus(1'b0, 8'h08, 32'h0, "after midreset ctrl");
        checkOutput("after midreset ctrl const", last_rd, 32'(RESET_WAIT) << 4);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            int          sel;
            logic [31:0] wd;
            sel = $urandom_range(0, 99);
            wd  = $urandom;
            if (sel < 35) begin
                applyStimulus(1'b1, 8'h00, wd, "rnd push");
            end else if (sel < 63) begin
                applyStimulus(1'b0, 8'h00, 32'h0, "rnd pop");
            end else if (sel < 70) begin
                applyStimulus(1'b0, 8'h04 | 8'($urandom_range(0, 3)), 32'h0, "rnd status");
            end else if (sel < 77) begin
                wd = (wd & 32'hFFFFFF0D) | (32'($urandom_range(0, 3)) << 4);
                if ($urandom_range(0, 9) != 0) wd[1] = 1'b0;
                applyStimulus(1'b1, 8'h08, wd, "rnd ctrl wr");
            end else if (sel < 82) begin
                applyStimulus(1'b0, 8'h08, 32'h0, "rnd ctrl rd");
            end else if (sel < 88) begin
                applyStimulus(1'b0, 8'h0C, 32'h0, "rnd isr rd");
            end else if (sel < 93) begin
                applyStimulus(1'b1, 8'h0C, wd, "rnd isr w1c");
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(16, 255)), wd, "rnd unmapped");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    // Absolute backstop so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no completion, expected end of test");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
